// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: Mem2Wb writeback, MDU valid/ready result,
// and the arbitrated RegFile write plus the stall request to the hazard unit.
interface wb_port_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic              PipeWe;
   logic [ADDR_W-1:0] PipeAddr;
   logic [DATA_W-1:0] PipeData;
   logic              MduValid;
   logic [ADDR_W-1:0] MduAddr;
   logic [DATA_W-1:0] MduData;
   logic              MduReady;
   logic              RfWe;
   logic [ADDR_W-1:0] RfAddr;
   logic [DATA_W-1:0] RfData;
   logic              StallReq;

   modport slave (
      input  PipeWe, PipeAddr, PipeData, MduValid, MduAddr, MduData,
      output MduReady, RfWe, RfAddr, RfData, StallReq
   );

   modport master (
      output PipeWe, PipeAddr, PipeData, MduValid, MduAddr, MduData,
      input  MduReady, RfWe, RfAddr, RfData, StallReq
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the RegFile write port between the committed Mem2Wb writeback and
// the MDU result; requests a pipeline bubble when the MDU has starved too long.
module wb_port_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input logic              Clk,
   input logic              Rst,
   wb_port_arbiter_if.slave bus
);
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STARVE = 1'b1
   } state_e;

   localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
   localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

   state_e            state_q, state_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic              stall_req_q, stall_req_d;
   logic              pipe_eff_s;
   logic              handshake_s;
   logic              blocked_s;

   // Writes to x0 never occupy the port, so they leave the slot free for the MDU.
   always_comb begin
      pipe_eff_s  = bus.PipeWe && (bus.PipeAddr != {ADDR_W{1'b0}});
      handshake_s = bus.MduValid && !pipe_eff_s;
      blocked_s   = bus.MduValid && pipe_eff_s;
   end

   assign bus.MduReady = !pipe_eff_s;

   // Write-port mux; an MDU result aimed at x0 is consumed without a write.
   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (pipe_eff_s) begin
         rf_we_d   = 1'b1;
         rf_addr_d = bus.PipeAddr;
         rf_data_d = bus.PipeData;
      end else if (handshake_s && (bus.MduAddr != {ADDR_W{1'b0}})) begin
         rf_we_d   = 1'b1;
         rf_addr_d = bus.MduAddr;
         rf_data_d = bus.MduData;
      end else begin
         rf_we_d   = 1'b0;
      end
   end

   // Starvation tracking: any cycle that is not blocked (handshake or no
   // request) clears the count and leaves STARVE.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      state_d    = state_q;
      if (blocked_s) begin
         if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end else begin
            wait_cnt_d = wait_cnt_q;
         end
      end else begin
         wait_cnt_d = 4'd0;
      end
      case (state_q)
         IDLE: begin
            if (blocked_s && (wait_cnt_q == WAIT_LAST)) begin
               state_d = STARVE;
            end else begin
               state_d = IDLE;
            end
         end
         STARVE: begin
            if (handshake_s || !bus.MduValid) begin
               state_d = IDLE;
            end else begin
               state_d = STARVE;
            end
         end
         default: state_d = IDLE;
      endcase
      stall_req_d = (state_d == STARVE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= 4'd0;
         rf_we_q     <= 1'b0;
         rf_addr_q   <= {ADDR_W{1'b0}};
         rf_data_q   <= {DATA_W{1'b0}};
         stall_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         rf_we_q     <= rf_we_d;
         rf_addr_q   <= rf_addr_d;
         rf_data_q   <= rf_data_d;
         stall_req_q <= stall_req_d;
      end
   end

   assign bus.RfWe     = rf_we_q;
   assign bus.RfAddr   = rf_addr_q;
   assign bus.RfData   = rf_data_q;
   assign bus.StallReq = stall_req_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a run-length model checked every cycle
// plus literal expectations at key points of each scenario.
module tb_wb_port_arbiter;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int MAX_WAIT = 4;

   logic Clk;
   logic Rst;
   int   checks;
   int   errors;
   bit   run_chk;

   wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Model: expected write port contents and the length of the current run of
   // consecutive cycles in which a valid MDU result was refused.
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   int                m_run;

   always @(posedge Clk) begin
      if (Rst) begin
         m_we   <= 1'b0;
         m_addr <= '0;
         m_data <= '0;
         m_run  <= 0;
      end else begin
         if (bus.PipeWe && bus.PipeAddr != 5'd0) begin
            m_we   <= 1'b1;
            m_addr <= bus.PipeAddr;
            m_data <= bus.PipeData;
         end else if (bus.MduValid && bus.MduAddr != 5'd0) begin
            m_we   <= 1'b1;
            m_addr <= bus.MduAddr;
            m_data <= bus.MduData;
         end else begin
            m_we   <= 1'b0;
         end
         if (bus.MduValid && bus.PipeWe && bus.PipeAddr != 5'd0) m_run <= m_run + 1;
         else m_run <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      if (run_chk) begin
         chk("cyc_rfwe",     64'(bus.RfWe),     64'(m_we));
         chk("cyc_rfaddr",   64'(bus.RfAddr),   64'(m_addr));
         chk("cyc_rfdata",   64'(bus.RfData),   64'(m_data));
         chk("cyc_stall",    64'(bus.StallReq), 64'(m_run >= MAX_WAIT));
         chk("cyc_mduready", 64'(bus.MduReady), 64'(!(bus.PipeWe && bus.PipeAddr != 5'd0)));
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pipe(input logic we, input logic [4:0] a, input logic [63:0] d);
      bus.PipeWe   = we;
      bus.PipeAddr = a;
      bus.PipeData = d;
   endtask

   task automatic mdu(input logic v, input logic [4:0] a, input logic [63:0] d);
      bus.MduValid = v;
      bus.MduAddr  = a;
      bus.MduData  = d;
   endtask

   task automatic out_is(input string name, input logic we, input logic [4:0] a,
                         input logic [63:0] d, input logic st);
      chk({name, "_we"},    64'(bus.RfWe),     64'(we));
      chk({name, "_addr"},  64'(bus.RfAddr),   64'(a));
      chk({name, "_data"},  bus.RfData,        d);
      chk({name, "_stall"}, 64'(bus.StallReq), 64'(st));
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      run_chk = 1'b0;
      Rst     = 1'b1;
      pipe(1'b1, 5'd3, 64'hA3);
      mdu(1'b1, 5'd7, 64'h77);

      // 1: reset with both sources active
      tick();
      run_chk = 1'b1;
      tick();
      out_is("rst", 1'b0, 5'd0, 64'h0, 1'b0);
      chk("rst_mduready", 64'(bus.MduReady), 64'd0);
      chk("rst_model_we", 64'(m_we), 64'd0);
      Rst = 1'b0;
      tick();
      out_is("rel", 1'b1, 5'd3, 64'hA3, 1'b0);
      pipe(1'b0, 5'd0, 64'h0);
      mdu(1'b0, 5'd0, 64'h0);
      tick();

      // 2: pipeline only
      pipe(1'b1, 5'd5, 64'hDEAD);
      tick();
      out_is("pipe", 1'b1, 5'd5, 64'hDEAD, 1'b0);
      chk("pipe_model_data", m_data, 64'hDEAD);
      pipe(1'b0, 5'd0, 64'h0);
      tick();
      out_is("pipe_hold", 1'b0, 5'd5, 64'hDEAD, 1'b0);

      // 3: collision for two cycles, then the bubble
      mdu(1'b1, 5'd7, 64'h11);
      pipe(1'b1, 5'd2, 64'h22);
      #1 chk("col_ready0", 64'(bus.MduReady), 64'd0);
      tick();
      out_is("col1", 1'b1, 5'd2, 64'h22, 1'b0);
      pipe(1'b1, 5'd2, 64'h23);
      tick();
      out_is("col2", 1'b1, 5'd2, 64'h23, 1'b0);
      pipe(1'b0, 5'd0, 64'h0);
      #1 chk("col_ready1", 64'(bus.MduReady), 64'd1);
      tick();
      out_is("col_mdu", 1'b1, 5'd7, 64'h11, 1'b0);
      mdu(1'b0, 5'd0, 64'h0);
      tick();

      // 4: starvation raises StallReq after the 4th blocked cycle
      mdu(1'b1, 5'd7, 64'h55);
      for (int i = 1; i <= 6; i++) begin
         pipe(1'b1, 5'd4, 64'(64'h40 + i));
         tick();
         chk("starve_stall", 64'(bus.StallReq), 64'(i >= 4));
      end
      chk("starve_model_run", 64'(m_run), 64'd6);
      pipe(1'b0, 5'd0, 64'h0);
      tick();
      out_is("starve_mdu", 1'b1, 5'd7, 64'h55, 1'b0);
      mdu(1'b0, 5'd0, 64'h0);
      tick();

      // 5: pipeline write to x0 grants the MDU; MDU result to x0 is dropped
      pipe(1'b1, 5'd0, 64'hBAD);
      mdu(1'b1, 5'd9, 64'h99);
      #1 chk("x0_ready", 64'(bus.MduReady), 64'd1);
      tick();
      out_is("x0_pipe", 1'b1, 5'd9, 64'h99, 1'b0);
      pipe(1'b0, 5'd0, 64'h0);
      mdu(1'b1, 5'd0, 64'h5);
      tick();
      out_is("x0_mdu", 1'b0, 5'd9, 64'h99, 1'b0);
      mdu(1'b0, 5'd0, 64'h0);
      tick();

      // 6: reset while in STARVE
      mdu(1'b1, 5'd12, 64'hC);
      pipe(1'b1, 5'd6, 64'h66);
      repeat (5) tick();
      chk("pre_rst_stall", 64'(bus.StallReq), 64'd1);
      Rst = 1'b1;
      tick();
      out_is("mid_rst", 1'b0, 5'd0, 64'h0, 1'b0);
      Rst = 1'b0;
      mdu(1'b1, 5'd13, 64'hD);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("post_rst_stall", 64'(bus.StallReq), 64'(i >= 4));
      end
      pipe(1'b0, 5'd0, 64'h0);
      tick();
      out_is("post_rst_mdu", 1'b1, 5'd13, 64'hD, 1'b0);
      mdu(1'b0, 5'd0, 64'h0);
      tick();
      out_is("idle_end", 1'b0, 5'd13, 64'hD, 1'b0);
      tick();

      run_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
